// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the boxer health blocks (player and opponent side).
//   - state_t      : health tracker FSM encoding (ALIVE / INVULN / DEAD), 2 bits
//   - HEALTH_W     : width of the health value
//   - MAX_HEALTH_DEF / HIT_DAMAGE_DEF : default tuning reused by both sides
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int HEALTH_W = 4;

    localparam logic [HEALTH_W-1:0] MAX_HEALTH_DEF = 4'd10;
    localparam logic [HEALTH_W-1:0] HIT_DAMAGE_DEF = 4'd2;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

endpackage

// File: rtl/player_health_if.sv
// -----------------------------------------------------------------------------
// player_health_if
// Bundle between the game logic and the player health tracker.
//   restart     : synchronous round restart, level, active-high
//   enemy_punch : opponent punch level (held for the whole punch)
//   can_be_hit  : 0 while the player is blocking
//   health      : current health (registered)
//   dead        : 1 while health == 0
//   hurt        : one-cycle pulse per landed hit
//   invuln      : 1 during the post-hit immunity window
//   dbg_state   : current tracker FSM state, for observation only
// Handshake: there is no valid/ready pairing here; every input is a level
// sampled on each rising clock edge and every output is a registered level
// that is valid one cycle after the edge that produced it.
// Modports: master = game/test side driving the inputs, slave = tracker.
// -----------------------------------------------------------------------------
interface player_health_if;
    import game_pkg::*;

    logic                restart;
    logic                enemy_punch;
    logic                can_be_hit;
    logic [HEALTH_W-1:0] health;
    logic                dead;
    logic                hurt;
    logic                invuln;
    state_t              dbg_state;

    modport master (
        output restart, enemy_punch, can_be_hit,
        input  health, dead, hurt, invuln, dbg_state
    );

    modport slave (
        input  restart, enemy_punch, can_be_hit,
        output health, dead, hurt, invuln, dbg_state
    );

endinterface

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// 1-bit rising-edge detector with a reset preload and a synchronous preset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_preset   : synchronous preload; the history takes i_d and no edge is
//                reported this cycle
//   i_d        : level input
//   o_rise     : combinational i_d & ~previous i_d
// RST_VAL = 1 means a level already high when reset releases is never seen
// as an edge; it must drop and rise again. Also used for the rgo/lgo keys.
// -----------------------------------------------------------------------------
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_preset,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            // History follows the input every cycle, preset or not.
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev & ~i_preset;

endmodule

// File: rtl/player_health.sv
// -----------------------------------------------------------------------------
// player_health
// Health tracker for the player boxer. Counts landed opponent punches, applies
// a post-hit immunity window and flags death.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : player_health_if.slave (restart, enemy_punch, can_be_hit in;
//             health, dead, hurt, invuln, dbg_state out)
// Optional feature: define PLAYER_HEALTH_REGEN_EN to add slow health
// regeneration while ALIVE (parameter REGEN_CYCLES).
// -----------------------------------------------------------------------------
module player_health
    import game_pkg::*;
#(
    parameter logic [HEALTH_W-1:0] MAX_HEALTH    = MAX_HEALTH_DEF,
    parameter logic [HEALTH_W-1:0] HIT_DAMAGE    = HIT_DAMAGE_DEF,
    parameter int unsigned         INVULN_CYCLES = 25000000,
    parameter int                  CNT_W         = 25
`ifdef PLAYER_HEALTH_REGEN_EN
    ,
    parameter int unsigned         REGEN_CYCLES  = 100000000
`endif
) (
    input  logic            clock,
    input  logic            reset_n,
    player_health_if.slave  bus
);

    state_t              r_state, w_state_nxt;
    logic [HEALTH_W-1:0] r_health, w_health_nxt;
    logic                r_dead, w_dead_nxt;
    logic                r_hurt, w_hurt_nxt;
    logic                r_invuln, w_invuln_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_punch_edge;
    logic                w_landed;

`ifdef PLAYER_HEALTH_REGEN_EN
    localparam int REGEN_W = $clog2(REGEN_CYCLES) + 1;
    logic [REGEN_W-1:0]  r_regen, w_regen_nxt;
`endif

    rise_detect #(.RST_VAL(1'b1)) u_punch_edge (
        .clk      (clock),
        .rst_n    (reset_n),
        .i_preset (bus.restart),
        .i_d      (bus.enemy_punch),
        .o_rise   (w_punch_edge)
    );

    // Only a fresh, unblocked punch while ALIVE can land.
    assign w_landed = w_punch_edge & bus.can_be_hit & (r_state == ST_ALIVE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_ALIVE;
            r_health <= MAX_HEALTH;
            r_dead   <= 1'b0;
            r_hurt   <= 1'b0;
            r_invuln <= 1'b0;
            r_cnt    <= '0;
`ifdef PLAYER_HEALTH_REGEN_EN
            r_regen  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_health <= w_health_nxt;
            r_dead   <= w_dead_nxt;
            r_hurt   <= w_hurt_nxt;
            r_invuln <= w_invuln_nxt;
            r_cnt    <= w_cnt_nxt;
`ifdef PLAYER_HEALTH_REGEN_EN
            r_regen  <= w_regen_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_health_nxt = r_health;
        w_dead_nxt   = r_dead;
        w_hurt_nxt   = 1'b0;
        w_invuln_nxt = r_invuln;
        w_cnt_nxt    = r_cnt;
`ifdef PLAYER_HEALTH_REGEN_EN
        w_regen_nxt  = '0;
`endif
        if (bus.restart) begin
            // Restart overrides anything that happens in the same cycle.
            w_state_nxt  = ST_ALIVE;
            w_health_nxt = MAX_HEALTH;
            w_dead_nxt   = 1'b0;
            w_invuln_nxt = 1'b0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (w_landed) begin
                        w_hurt_nxt = 1'b1;
                        // Compare before subtracting so health never wraps.
                        if (r_health > HIT_DAMAGE) begin
                            w_health_nxt = r_health - HIT_DAMAGE;
                            w_state_nxt  = ST_INVULN;
                            w_invuln_nxt = 1'b1;
                            w_cnt_nxt    = CNT_W'(INVULN_CYCLES - 1);
                        end else begin
                            w_health_nxt = '0;
                            w_dead_nxt   = 1'b1;
                            w_state_nxt  = ST_DEAD;
                        end
                    end
`ifdef PLAYER_HEALTH_REGEN_EN
                    else if (r_health < MAX_HEALTH) begin
                        if (r_regen == REGEN_W'(REGEN_CYCLES - 1)) begin
                            w_health_nxt = r_health + 4'd1;
                        end else begin
                            w_regen_nxt = r_regen + 1'b1;
                        end
                    end
`endif
                end
                ST_INVULN: begin
                    // Counter starts at INVULN_CYCLES-1, so invuln stays high
                    // for exactly INVULN_CYCLES cycles.
                    if (r_cnt == '0) begin
                        w_state_nxt  = ST_ALIVE;
                        w_invuln_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                ST_DEAD: begin
                    w_health_nxt = '0;
                    w_dead_nxt   = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_ALIVE;
                end
            endcase
        end
    end

    assign bus.health    = r_health;
    assign bus.dead      = r_dead;
    assign bus.hurt      = r_hurt;
    assign bus.invuln    = r_invuln;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_player_health.sv
// Self-checking bench for player_health with small parameters
// (MAX_HEALTH=5, HIT_DAMAGE=2, INVULN_CYCLES=4, REGEN_CYCLES=8 when enabled).
module tb_player_health;
  import game_pkg::*;

  localparam logic [3:0] MAXH  = 4'd5;
  localparam logic [3:0] DMG   = 4'd2;
  localparam int         INV   = 4;
  localparam int         REGEN = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  player_health_if bus();

  player_health #(
    .MAX_HEALTH    (MAXH),
    .HIT_DAMAGE    (DMG),
    .INVULN_CYCLES (INV),
    .CNT_W         (3)
`ifdef PLAYER_HEALTH_REGEN_EN
    ,
    .REGEN_CYCLES  (REGEN)
`endif
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Game-rule view: health points, a count of immune cycles still to show,
  // a death flag and the last punch level seen.
  int m_health;
  bit m_dead;
  bit m_hurt;
  int m_immune;
  bit m_last;
`ifdef PLAYER_HEALTH_REGEN_EN
  int m_regen;
`endif

  task automatic model_reset();
    m_health = int'(MAXH);
    m_dead   = 1'b0;
    m_hurt   = 1'b0;
    m_immune = 0;
    m_last   = 1'b1;
`ifdef PLAYER_HEALTH_REGEN_EN
    m_regen  = 0;
`endif
  endtask

  task automatic model_step();
    bit edge_seen;
    bit alive;
    edge_seen = bus.enemy_punch && !m_last;
    m_last = bus.enemy_punch;
    m_hurt = 1'b0;
    if (bus.restart) begin
      m_health = int'(MAXH);
      m_dead   = 1'b0;
      m_immune = 0;
`ifdef PLAYER_HEALTH_REGEN_EN
      m_regen  = 0;
`endif
    end else begin
      alive = !m_dead && (m_immune == 0);
      if (m_immune > 0) m_immune--;
      if (alive && edge_seen && bus.can_be_hit) begin
        m_hurt = 1'b1;
        if (m_health > int'(DMG)) begin
          m_health -= int'(DMG);
          m_immune = INV;
        end else begin
          m_health = 0;
          m_dead   = 1'b1;
        end
`ifdef PLAYER_HEALTH_REGEN_EN
        m_regen = 0;
`endif
      end
`ifdef PLAYER_HEALTH_REGEN_EN
      else if (alive && m_health < int'(MAXH)) begin
        m_regen++;
        if (m_regen == REGEN) begin
          m_health++;
          m_regen = 0;
        end
      end else begin
        m_regen = 0;
      end
`endif
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_state;
    exp_state = m_dead ? 32'(ST_DEAD) : ((m_immune > 0) ? 32'(ST_INVULN) : 32'(ST_ALIVE));
    check_eq("health", 32'(bus.health), 32'(m_health));
    check_eq("dead",   32'(bus.dead),   32'(m_dead));
    check_eq("hurt",   32'(bus.hurt),   32'(m_hurt));
    check_eq("invuln", 32'(bus.invuln), 32'(m_immune > 0));
    check_eq("state",  32'(bus.dbg_state), exp_state);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: apply inputs, advance one clock, check.
  task automatic step(input bit p, input bit cbh, input bit rs);
    bus.enemy_punch = p;
    bus.can_be_hit  = cbh;
    bus.restart     = rs;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.enemy_punch = 1'b0;
    bus.can_be_hit  = 1'b1;
    bus.restart     = 1'b0;
    reset_n         = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;

    // 1: 3-cycle punch lands once, then a 4-cycle immunity window.
    idle(2);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    idle(6);

    // 2: blocked punch after a restart.
    step(0, 1, 1);
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); idle(2);

    // 3: hit to 3, second edge inside the window ignored, fresh edge -> 1.
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); idle(5);
    step(1, 1, 0); idle(5);

    // 4: fatal hit, dead is absorbing, restart revives.
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
    step(0, 1, 1); idle(2);

    // 5a: punch held through restart is not a hit until it re-rises.
    step(1, 1, 0); step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
    step(0, 1, 0); step(1, 1, 0); idle(6);

    // 5b: punch held through reset release.
    bus.enemy_punch = 1'b1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 1, 0); step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);

    // 6: asynchronous reset mid-window, seen before any clock edge.
    step(0, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_health", 32'(bus.health), 32'(MAXH));
    check_eq("async_invuln", 32'(bus.invuln), 32'd0);
    model_reset();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    idle(2);

`ifdef PLAYER_HEALTH_REGEN_EN
    // Regen: hit to 3, then idle long enough to climb back to the cap.
    step(1, 1, 0);
    idle(30);
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
